// File: rtl/fifo_async_rd_fwft.sv
// Read-side controller of the dual-clock FIFO: synchronises the writer's Gray pointer,
// fetches from the dual-port RAM and presents first-word-fall-through data with level flags.
module fifo_async_rd_fwft #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WID    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 4
) (
  input  logic                  RClk,
  input  logic                  PresetFull,
  input  logic                  rd_clear,
  input  logic [ADDR_WID:0]     wr_ptr_gray,
  output logic [ADDR_WID:0]     rd_ptr_gray,
  output logic                  ram_rd_en,
  output logic [ADDR_WID-1:0]   ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WID+1:0]   rd_level
);

  localparam int PW = ADDR_WID + 1;
  localparam int LW = ADDR_WID + 2;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Write-pointer synchroniser chain
  logic [PW-1:0] sync_d   [SYNC_STAGES];
  logic [PW-1:0] sync_reg [SYNC_STAGES];

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = wr_ptr_gray;
    end else begin : g_rest
      assign sync_d[gi] = sync_reg[gi-1];
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
      if (PresetFull) begin
        sync_reg[gi] <= '0;
      end else begin
        sync_reg[gi] <= sync_d[gi];
      end
    end
  end

  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] wr_bin_next;
  assign wr_bin_s    = gray2bin(sync_reg[SYNC_STAGES-1]);
  assign wr_bin_next = gray2bin(sync_reg[SYNC_STAGES-2]);

  // Pointer and output-buffer state
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]         rd_ptr_gray_reg;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic [DATA_WIDTH-1:0] skid_reg, skid_next;
  logic                  dout_valid_reg, dout_valid_next;
  logic                  skid_valid_reg, skid_valid_next;
  logic                  inflight_reg;
  logic                  empty_reg, almost_empty_reg;
  logic [LW-1:0]         rd_level_reg, rd_level_next;

  logic [PW-1:0] avail;
  logic [1:0]    occ, occ_next;
  logic          pop;
  logic          fetch;

  assign avail = wr_bin_s - rd_ptr_reg;
  assign occ   = {1'b0, dout_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, inflight_reg};
  assign pop   = dout_valid_reg & dout_ready;
  // pop implies occ >= 1, so occ - pop cannot underflow
  assign fetch = (avail != '0) && ((occ - {1'b0, pop}) < 2'd2) && !rd_clear;

  always_comb begin
    dout_next       = dout_reg;
    skid_next       = skid_reg;
    dout_valid_next = dout_valid_reg;
    skid_valid_next = skid_valid_reg;
    rd_ptr_next     = rd_ptr_reg + {{(PW-1){1'b0}}, fetch};

    if (rd_clear) begin
      dout_valid_next = 1'b0;
      skid_valid_next = 1'b0;
      rd_ptr_next     = wr_bin_s;
    end else begin
      if (pop) begin
        dout_next       = skid_reg;
        dout_valid_next = skid_valid_reg;
        skid_valid_next = 1'b0;
      end
      // Returning RAM word lands in the first free slot, keeping FIFO order
      if (inflight_reg) begin
        if (!dout_valid_next) begin
          dout_next       = ram_rd_data;
          dout_valid_next = 1'b1;
        end else begin
          skid_next       = ram_rd_data;
          skid_valid_next = 1'b1;
        end
      end
    end

    occ_next      = {1'b0, dout_valid_next} + {1'b0, skid_valid_next} + {1'b0, fetch};
    rd_level_next = {1'b0, wr_bin_next - rd_ptr_next} + {{(LW-2){1'b0}}, occ_next};
  end

  always_ff @(posedge RClk or posedge PresetFull) begin
    if (PresetFull) begin
      rd_ptr_reg       <= '0;
      rd_ptr_gray_reg  <= '0;
      dout_reg         <= '0;
      skid_reg         <= '0;
      dout_valid_reg   <= 1'b0;
      skid_valid_reg   <= 1'b0;
      inflight_reg     <= 1'b0;
      empty_reg        <= 1'b1;
      almost_empty_reg <= 1'b1;
      rd_level_reg     <= '0;
    end else begin
      rd_ptr_reg       <= rd_ptr_next;
      rd_ptr_gray_reg  <= bin2gray(rd_ptr_reg);
      dout_reg         <= dout_next;
      skid_reg         <= skid_next;
      dout_valid_reg   <= dout_valid_next;
      skid_valid_reg   <= skid_valid_next;
      inflight_reg     <= fetch;
      empty_reg        <= !dout_valid_next;
      almost_empty_reg <= (rd_level_next <= LW'(AE_THRESH));
      rd_level_reg     <= rd_level_next;
    end
  end

  assign rd_ptr_gray  = rd_ptr_gray_reg;
  assign ram_rd_en    = fetch;
  assign ram_rd_addr  = rd_ptr_reg[ADDR_WID-1:0];
  assign dout         = dout_reg;
  assign dout_valid   = dout_valid_reg;
  assign empty        = empty_reg;
  assign almost_empty = almost_empty_reg;
  assign rd_level     = rd_level_reg;

endmodule

// File: tb/tb_fifo_async_rd_fwft.sv
// Directed bench for the FIFO read side: models the writer and the RAM, scoreboards every word.
module tb_fifo_async_rd_fwft;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int PW = AW + 1;
  localparam int LW = AW + 2;

  logic          RClk = 1'b0;
  logic          PresetFull;
  logic          rd_clear;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_ptr_gray;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          empty;
  logic          almost_empty;
  logic [LW-1:0] rd_level;

  fifo_async_rd_fwft #(
    .DATA_WIDTH(DW), .ADDR_WID(AW), .SYNC_STAGES(2), .AE_THRESH(4)
  ) dut (
    .RClk(RClk), .PresetFull(PresetFull), .rd_clear(rd_clear),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level)
  );

  always #5 RClk = ~RClk;

  // RAM read port model, one-cycle latency
  logic [DW-1:0] mem [256];
  always @(posedge RClk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] exp_rd_ptr;
  logic [PW-1:0] ptr_lag;
  logic [PW-1:0] prev_gray;
  logic [DW-1:0] exp_q [$];
  int            fetch_cnt, pop_cnt, cyc, last_pop, n;
  bit            gap_chk;

  task automatic push(input logic [DW-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_bin      = wr_bin + 1'b1;
    wr_ptr_gray = b2g(wr_bin);
  endtask

  task automatic step(input logic rdy, input logic clr);
    logic          pop_now;
    logic [DW-1:0] e;
    @(negedge RClk);
    cyc++;
    check_eq("rd_ptr_gray", rd_ptr_gray, b2g(ptr_lag));
    if (gap_chk) check_eq("gray_1bit", $countones(rd_ptr_gray ^ prev_gray) <= 1, 1);
    prev_gray = rd_ptr_gray;
    ptr_lag   = exp_rd_ptr;
    check_eq("empty_vs_valid", empty, !dout_valid);
    check_eq("ae_vs_level", almost_empty, rd_level <= 4);
    dout_ready = rdy;
    rd_clear   = clr;
    #1;
    pop_now = dout_valid & rdy & !clr;
    if (clr) check_eq("clr_no_fetch", ram_rd_en, 0);
    if (ram_rd_en) begin
      check_eq("rd_addr", ram_rd_addr, exp_rd_ptr[AW-1:0]);
      check_eq("occ_at_fetch", (fetch_cnt - pop_cnt - int'(pop_now)) < 2, 1);
    end
    if (pop_now) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("dout", dout, e);
      end
      if (gap_chk && last_pop >= 0) check_eq("gap", cyc - last_pop, 1);
      last_pop = cyc;
      pop_cnt++;
      $display("POP cyc %0d data %02h", cyc, dout);
    end
    if (clr) begin
      exp_rd_ptr = wr_bin;
      exp_q.delete();
      fetch_cnt = 0;
      pop_cnt   = 0;
    end else if (ram_rd_en) begin
      exp_rd_ptr = exp_rd_ptr + 1'b1;
      fetch_cnt++;
    end
  endtask

  task automatic drain(input string tag, input int bound);
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1'b1, 1'b0);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    PresetFull  = 1'b1;
    rd_clear    = 1'b0;
    dout_ready  = 1'b0;
    wr_ptr_gray = '0;
    wr_bin      = '0;
    exp_rd_ptr  = '0;
    ptr_lag     = '0;
    prev_gray   = '0;
    fetch_cnt   = 0;
    pop_cnt     = 0;
    cyc         = 0;
    last_pop    = -1;
    gap_chk     = 1'b0;

    // Reset state
    repeat (3) @(negedge RClk);
    check_eq("rst_valid", dout_valid, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ae", almost_empty, 1);
    check_eq("rst_level", rd_level, 0);
    check_eq("rst_en", ram_rd_en, 0);
    check_eq("rst_gray", rd_ptr_gray, 0);
    PresetFull = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check_eq("idle_valid", dout_valid, 0);
    check_eq("idle_en", ram_rd_en, 0);
    check_eq("idle_level", rd_level, 0);

    // First word latency: SYNC_STAGES+2 edges
    step(1'b0, 1'b0);
    push(8'hA5);
    step(1'b0, 1'b0);
    check_eq("t2_valid_c1", dout_valid, 0);
    check_eq("t2_en_c1", ram_rd_en, 0);
    step(1'b0, 1'b0);
    check_eq("t2_en_c2", ram_rd_en, 1);
    step(1'b0, 1'b0);
    check_eq("t2_valid_c3", dout_valid, 0);
    step(1'b0, 1'b0);
    check_eq("t2_valid_c4", dout_valid, 1);
    check_eq("t2_dout", dout, 8'hA5);
    check_eq("t2_level", rd_level, 1);
    check_eq("t2_empty", empty, 0);
    check_eq("t2_ae", almost_empty, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("t2_after_empty", empty, 1);
    check_eq("t2_after_level", rd_level, 0);

    // 10-word stream, consumer always ready, no bubbles
    gap_chk  = 1'b1;
    last_pop = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      push(8'h10 + 8'(i));
    end
    drain("t3_drained", 20);
    repeat (2) step(1'b1, 1'b0);
    check_eq("t3_empty", empty, 1);
    check_eq("t3_level", rd_level, 0);
    check_eq("t3_ae", almost_empty, 1);

    // Fill to depth and drain twice; read pointer wraps 511 -> 0
    for (int r = 0; r < 2; r++) begin
      gap_chk = 1'b0;
      for (int i = 0; i < 256; i++) begin
        step(1'b0, 1'b0);
        push(8'(i) ^ 8'(8'h5A + r));
      end
      repeat (4) step(1'b0, 1'b0);
      check_eq("t4_level_full", rd_level, 256);
      check_eq("t4_ae_full", almost_empty, 0);
      check_eq("t4_valid", dout_valid, 1);
      check_eq("t4_head", dout, exp_q[0]);
      gap_chk  = 1'b1;
      last_pop = -1;
      drain("t4_drained", 300);
      repeat (2) step(1'b1, 1'b0);
      check_eq("t4_empty", empty, 1);
    end
    check_eq("t4_wrapped_ptr", exp_rd_ptr, 9'd11);
    gap_chk = 1'b0;

    // Ready toggling every cycle with 20 words
    for (int i = 0; i < 20; i++) begin
      step((i % 2) == 0, 1'b0);
      push(8'hC0 + 8'(i));
    end
    drain("t5_drained", 60);

    // Flush with 7 words pending
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0);
      push(8'h70 + 8'(i));
    end
    repeat (5) step(1'b0, 1'b0);
    check_eq("t6_level_pre", rd_level, 7);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("t6_valid", dout_valid, 0);
    check_eq("t6_level", rd_level, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_ae", almost_empty, 1);
    check_eq("t6_en", ram_rd_en, 0);
    step(1'b0, 1'b0);
    check_eq("t6_gray", rd_ptr_gray, b2g(wr_bin));
    step(1'b0, 1'b0);
    push(8'h3C);
    drain("t6_post_clear", 10);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      push(8'h90 + 8'(i));
    end
    repeat (2) step(1'b1, 1'b0);
    @(negedge RClk);
    #2;
    PresetFull  = 1'b1;
    wr_bin      = '0;
    wr_ptr_gray = '0;
    dout_ready  = 1'b0;
    #1;
    check_eq("mr_valid", dout_valid, 0);
    check_eq("mr_empty", empty, 1);
    check_eq("mr_ae", almost_empty, 1);
    check_eq("mr_level", rd_level, 0);
    check_eq("mr_en", ram_rd_en, 0);
    check_eq("mr_gray", rd_ptr_gray, 0);
    check_eq("mr_dout", dout, 0);
    exp_q.delete();
    exp_rd_ptr = '0;
    ptr_lag    = '0;
    prev_gray  = '0;
    fetch_cnt  = 0;
    pop_cnt    = 0;
    repeat (2) @(negedge RClk);
    PresetFull = 1'b0;
    step(1'b0, 1'b0);
    push(8'hE7);
    drain("mr_post_reset", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
